ritc_user_bus_master: RTL

- Initiator for the RITC datapath user register bus: user_sel, user_addr, user_wr, user_rd and user_dat in both directions.
- Takes single commands from a control source (PicoBlaze or PCI bridge) over a valid/ready handshake and converts each one into bus strobes.
- Supported commands: write, read, read-modify-write, and poll-until-match. The poll command is used for IDELAY/bitslip busy bits.
- Returns exactly one response per command over a valid/ready handshake.

---
 rtl/ritc_bus_pkg.sv | 37 +++
 rtl/ritc_bus_poll_ctr.sv | 61 ++++++
 rtl/ritc_user_bus_master.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ritc_bus_pkg.sv
// ---------------------------------------------------------------------------
// ritc_bus_pkg
// Shared definitions for the RITC user register bus master.
//   - command op codes carried on cmd_op_i
//   - FSM state encoding
//   - default bus widths
//   - datapath register map seen on user_addr_o
// ---------------------------------------------------------------------------
package ritc_bus_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 32;

    // Datapath register addresses.
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_RST_EN      = 4'h0;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_BITSLIP     = 4'h1;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_IDELAY_VAL  = 4'h2;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_IDELAY_CTRL = 4'h3;

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_RD   = 2'b01,
        OP_RMW  = 2'b10,
        OP_POLL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_MODIFY,
        ST_GAP,
        ST_RSP
    } state_e;

endpackage

// File: rtl/ritc_bus_poll_ctr.sv
// ---------------------------------------------------------------------------
// ritc_bus_poll_ctr
// Poll bookkeeping for the bus master: counts reads issued by a poll command,
// times the idle gap between poll reads, and flags match / limit reached.
//
// Ports:
//   user_clk_i, user_rst_n_i : clock, async active-low reset
//   poll_clr_i               : clear the read counter (new command accepted)
//   poll_inc_i               : one read strobe issued this cycle
//   gap_run_i                : master is in the GAP state this cycle
//   rd_dat_i                 : read data being sampled this cycle
//   cmp_dat_i, cmp_mask_i    : poll compare value and mask
//   match_o                  : masked read data equals masked compare value
//   limit_o                  : POLL_LIMIT reads have been issued
//   gap_done_o               : this is the last GAP cycle
// ---------------------------------------------------------------------------
module ritc_bus_poll_ctr #(
    parameter int DATA_WIDTH = 32,
    parameter int POLL_LIMIT = 255,
    parameter int POLL_GAP   = 15
) (
    input  logic                  user_clk_i,
    input  logic                  user_rst_n_i,
    input  logic                  poll_clr_i,
    input  logic                  poll_inc_i,
    input  logic                  gap_run_i,
    input  logic [DATA_WIDTH-1:0] rd_dat_i,
    input  logic [DATA_WIDTH-1:0] cmp_dat_i,
    input  logic [DATA_WIDTH-1:0] cmp_mask_i,
    output logic                  match_o,
    output logic                  limit_o,
    output logic                  gap_done_o
);

    logic [15:0] poll_cnt_q;
    logic [7:0]  gap_cnt_q;

    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            if (poll_clr_i) begin
                poll_cnt_q <= '0;
            end else if (poll_inc_i) begin
                poll_cnt_q <= poll_cnt_q + 16'd1;
            end
            // Rests at zero outside GAP, so it holds k-1 in the k-th GAP cycle.
            if (gap_run_i) begin
                gap_cnt_q <= gap_cnt_q + 8'd1;
            end else begin
                gap_cnt_q <= '0;
            end
        end
    end

    assign match_o    = ((rd_dat_i ^ cmp_dat_i) & cmp_mask_i) == '0;
    assign limit_o    = poll_cnt_q == 16'(POLL_LIMIT);
    assign gap_done_o = ({1'b0, gap_cnt_q} + 9'd1) == 9'(POLL_GAP);

endmodule

// File: rtl/ritc_user_bus_master.sv
// ---------------------------------------------------------------------------
// ritc_user_bus_master
// Initiator for the RITC datapath user register bus. Accepts one command at a
// time (write, read, read-modify-write, poll-until-match) and turns it into
// single-cycle user_wr / user_rd strobes, then returns one response.
//
// Ports:
//   user_clk_i, user_rst_n_i     : clock, async active-low reset
//   cmd_valid_i / cmd_ready_o    : command handshake (ready only in IDLE)
//   cmd_op_i, cmd_addr_i,
//   cmd_dat_i, cmd_mask_i        : command fields
//   rsp_valid_o / rsp_ready_i    : response handshake
//   rsp_dat_o, rsp_err_o         : read data / poll-exhausted flag
//   user_sel_o, user_addr_o,
//   user_wr_o, user_rd_o,
//   user_dat_o, user_dat_i       : register bus
//   busy_o                       : high whenever not IDLE
// ---------------------------------------------------------------------------
module ritc_user_bus_master
    import ritc_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LATENCY = 2,
    parameter int POLL_LIMIT = 255,
    parameter int POLL_GAP   = 15
) (
    input  logic                  user_clk_i,
    input  logic                  user_rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    input  logic [DATA_WIDTH-1:0] cmd_mask_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  user_sel_o,
    output logic [ADDR_WIDTH-1:0] user_addr_o,
    output logic                  user_wr_o,
    output logic                  user_rd_o,
    output logic [DATA_WIDTH-1:0] user_dat_o,
    input  logic [DATA_WIDTH-1:0] user_dat_i,
    output logic                  busy_o
);

    state_e                  state_q;
    op_e                     op_q;
    logic [DATA_WIDTH-1:0]   cmd_dat_q;
    logic [DATA_WIDTH-1:0]   cmd_mask_q;
    logic [DATA_WIDTH-1:0]   rd_q;
    logic [2:0]              lat_q;

    logic                    cmd_ready_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_dat_q;
    logic                    rsp_err_q;
    logic                    user_sel_q;
    logic                    user_wr_q;
    logic                    user_rd_q;
    logic [ADDR_WIDTH-1:0]   user_addr_q;
    logic [DATA_WIDTH-1:0]   user_dat_q;

    logic                    cmd_fire;
    logic                    lat_done;
    logic                    poll_match;
    logic                    poll_limit;
    logic                    gap_done;

    assign cmd_fire = cmd_valid_i & cmd_ready_q;
    // lat_q holds k-1 in the k-th RD_WAIT cycle; the last one samples user_dat_i.
    assign lat_done = ({1'b0, lat_q} + 4'd1) == 4'(RD_LATENCY);

    ritc_bus_poll_ctr #(
        .DATA_WIDTH (DATA_WIDTH),
        .POLL_LIMIT (POLL_LIMIT),
        .POLL_GAP   (POLL_GAP)
    ) u_poll_ctr (
        .user_clk_i   (user_clk_i),
        .user_rst_n_i (user_rst_n_i),
        .poll_clr_i   (cmd_fire),
        .poll_inc_i   (state_q == ST_RD),
        .gap_run_i    (state_q == ST_GAP),
        .rd_dat_i     (user_dat_i),
        .cmp_dat_i    (cmd_dat_q),
        .cmp_mask_i   (cmd_mask_q),
        .match_o      (poll_match),
        .limit_o      (poll_limit),
        .gap_done_o   (gap_done)
    );

    // NOTE: every register here, outputs included, is state and uses <=; the
    // async reset clears them at once, which is what aborts a transaction
    // mid-flight without emitting a response.
    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WR;
            cmd_dat_q   <= '0;
            cmd_mask_q  <= '0;
            rd_q        <= '0;
            lat_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            user_sel_q  <= 1'b0;
            user_wr_q   <= 1'b0;
            user_rd_q   <= 1'b0;
            user_addr_q <= '0;
            user_dat_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        op_q        <= op_e'(cmd_op_i);
                        cmd_dat_q   <= cmd_dat_i;
                        cmd_mask_q  <= cmd_mask_i;
                        user_addr_q <= cmd_addr_i;
                        cmd_ready_q <= 1'b0;
                        user_sel_q  <= 1'b1;
                        if (op_e'(cmd_op_i) == OP_WR) begin
                            user_wr_q  <= 1'b1;
                            user_dat_q <= cmd_dat_i;
                            state_q    <= ST_WR;
                        end else begin
                            user_rd_q <= 1'b1;
                            state_q   <= ST_RD;
                        end
                    end
                end

                ST_WR: begin
                    user_sel_q  <= 1'b0;
                    user_wr_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    // RMW reports the value the register held before the write.
                    rsp_dat_q   <= (op_q == OP_RMW) ? rd_q : '0;
                    rsp_err_q   <= 1'b0;
                    state_q     <= ST_RSP;
                end

                ST_RD: begin
                    user_sel_q <= 1'b0;
                    user_rd_q  <= 1'b0;
                    lat_q      <= '0;
                    state_q    <= ST_RD_WAIT;
                end

                ST_RD_WAIT: begin
                    if (!lat_done) begin
                        lat_q <= lat_q + 3'd1;
                    end else begin
                        lat_q <= '0;
                        rd_q  <= user_dat_i;
                        // Decide on the sampled value directly so a poll with
                        // no gap re-reads RD_LATENCY+1 cycles after the last.
                        case (op_q)
                            OP_RMW: begin
                                state_q <= ST_MODIFY;
                            end
                            OP_POLL: begin
                                if (poll_match || poll_limit) begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_dat_q   <= user_dat_i;
                                    rsp_err_q   <= !poll_match;
                                    state_q     <= ST_RSP;
                                end else if (POLL_GAP == 0) begin
                                    user_sel_q <= 1'b1;
                                    user_rd_q  <= 1'b1;
                                    state_q    <= ST_RD;
                                end else begin
                                    state_q <= ST_GAP;
                                end
                            end
                            default: begin
                                rsp_valid_q <= 1'b1;
                                rsp_dat_q   <= user_dat_i;
                                rsp_err_q   <= 1'b0;
                                state_q     <= ST_RSP;
                            end
                        endcase
                    end
                end

                ST_MODIFY: begin
                    user_dat_q <= (rd_q & ~cmd_mask_q) | (cmd_dat_q & cmd_mask_q);
                    user_sel_q <= 1'b1;
                    user_wr_q  <= 1'b1;
                    state_q    <= ST_WR;
                end

                ST_GAP: begin
                    if (gap_done) begin
                        user_sel_q <= 1'b1;
                        user_rd_q  <= 1'b1;
                        state_q    <= ST_RD;
                    end
                end

                ST_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rsp_dat_q   <= '0;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    user_sel_q  <= 1'b0;
                    user_wr_q   <= 1'b0;
                    user_rd_q   <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign user_sel_o  = user_sel_q;
    assign user_wr_o   = user_wr_q;
    assign user_rd_o   = user_rd_q;
    assign user_addr_o = user_addr_q;
    assign user_dat_o  = user_dat_q;
    assign busy_o      = state_q != ST_IDLE;

endmodule
